// File: rtl/ipm_distributed_fifo_v1_0.sv
// Single-clock FIFO on distributed RAM with occupancy count, almost flags,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module ipm_distributed_fifo_v1_0 #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int D = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0] mem [D];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses the flags registered before this edge, so a full FIFO
    // rejects a write even when a read frees a slot in the same cycle.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        count_next = data_count
                   + {{ADDR_WIDTH{1'b0}}, wr_acc}
                   - {{ADDR_WIDTH{1'b0}}, rd_acc};
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            data_count   <= count_next;
            full         <= (count_next == DEPTH);
            almost_full  <= (count_next >= AF_TH);
            empty        <= (count_next == '0);
            almost_empty <= (count_next <= AE_TH);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero while nothing is stored.
            assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_acc) begin
                    rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                end
            end
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_ipm_distributed_fifo_v1_0.sv
// Drives a standard-mode and an FWFT-mode FIFO with shared stimulus and checks
// both against a queue-based model every cycle.
module tb_ipm_distributed_fifo_v1_0;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] s_rd, f_rd;
    logic          s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
    logic          f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
    logic [AW:0]   s_cnt, f_cnt;

    ipm_distributed_fifo_v1_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd), .full(s_full), .almost_full(s_af), .empty(s_empty),
        .almost_empty(s_ae), .data_count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
    );

    ipm_distributed_fifo_v1_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd), .full(f_full), .almost_full(f_af), .empty(f_empty),
        .almost_empty(f_ae), .data_count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    // Reference model: the stored words in order, plus the last popped word.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_std = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_std = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = wr_en && was_full;
            m_unf = rd_en && was_empty;
            if (rd_en && !was_empty) m_std = q.pop_front();
            if (wr_en && !was_full) q.push_back(wr_data);
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        rst = r; wr_en = w; rd_en = rd; wr_data = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            logic [DW-1:0] head;
            n    = q.size();
            head = (n != 0) ? q[0] : '0;
            chk("count",        32'(s_cnt),   32'(n));
            chk("full",         32'(s_full),  32'(n == D));
            chk("empty",        32'(s_empty), 32'(n == 0));
            chk("almost_full",  32'(s_af),    32'(n >= D - 2));
            chk("almost_empty", 32'(s_ae),    32'(n <= 2));
            chk("overflow",     32'(s_ovf),   32'(m_ovf));
            chk("underflow",    32'(s_unf),   32'(m_unf));
            chk("rd_data_std",  32'(s_rd),    32'(m_std));
            chk("fwft_count",   32'(f_cnt),   32'(n));
            chk("fwft_empty",   32'(f_empty), 32'(n == 0));
            chk("fwft_full",    32'(f_full),  32'(n == D));
            chk("fwft_ovf_unf", 32'({f_ovf, f_unf, f_af, f_ae}),
                32'({m_ovf, m_unf, n >= D - 2, n <= 2}));
            chk("rd_data_fwft", 32'(f_rd),    32'(head));
        end
    end

    initial begin
        int wprob;
        int rprob;
        repeat (2) @(posedge clk);
        #1;
        cycle(1, 0, 0, 16'h0);
        chk_en = 1;
        chk("rst_count", 32'(s_cnt), 32'd0);
        chk("rst_flags", 32'({s_empty, s_ae, s_full, s_af, s_ovf, s_unf}), 32'b110000);
        chk("rst_rd", 32'(s_rd), 32'h0);

        // Fill 0x0001..0x0010
        for (int i = 0; i < D; i++) begin
            cycle(0, 1, 0, 16'(i + 1));
            if (i == 12) chk("af_before_14", 32'(s_af), 32'd0);
            if (i == 13) chk("af_after_14", 32'(s_af), 32'd1);
        end
        chk("full_after_16", 32'({s_full, s_cnt}), 32'({1'b1, 5'd16}));

        // Write while full
        cycle(0, 1, 0, 16'hDEAD);
        chk("ovf_pulse", 32'({s_ovf, s_cnt}), 32'({1'b1, 5'd16}));
        cycle(0, 0, 0, 16'h0);
        chk("ovf_drop", 32'(s_ovf), 32'd0);

        // Drain in order
        for (int i = 0; i < D; i++) begin
            cycle(0, 0, 1, 16'h0);
            chk("order", 32'(s_rd), 32'(i + 1));
        end
        chk("empty_after_drain", 32'(s_empty), 32'd1);

        // Read while empty
        cycle(0, 0, 1, 16'h0);
        chk("unf_pulse", 32'({s_unf, s_rd}), 32'({1'b1, 16'h0010}));
        cycle(0, 0, 0, 16'h0);

        // Simultaneous request at empty
        cycle(0, 1, 1, 16'h0055);
        chk("simul_empty", 32'({s_unf, s_cnt}), 32'({1'b1, 5'd1}));

        // Bring to 5 words, then 40 cycles of simultaneous read/write
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 16'(16'h0060 + i));
        for (int i = 0; i < 40; i++) cycle(0, 1, 1, 16'(16'h0100 + i));
        chk("simul_count", 32'(s_cnt), 32'd5);

        // Reset mid-stream with 9 words stored and wr_en high
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 16'(16'h0200 + i));
        chk("nine_words", 32'(s_cnt), 32'd9);
        cycle(1, 1, 0, 16'hBEEF);
        chk("midrst", 32'({s_cnt, s_empty, s_ovf, s_unf, s_rd}), 32'({5'd0, 3'b100, 16'h0}));
        cycle(0, 1, 0, 16'h1234);
        cycle(0, 0, 1, 16'h0);
        chk("first_after_rst", 32'(s_rd), 32'h1234);

        // FWFT show and pop
        cycle(0, 1, 0, 16'hA5A5);
        chk("fwft_show", 32'({f_empty, f_rd}), 32'({1'b0, 16'hA5A5}));
        cycle(0, 0, 1, 16'h0);
        chk("fwft_pop", 32'({f_empty, f_rd}), 32'({1'b1, 16'h0}));

        // Randomised traffic with varying bias to reach both ends
        for (int blk = 0; blk < 15; blk++) begin
            wprob = $urandom_range(10, 90);
            rprob = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                cycle(($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 99) < wprob),
                      ($urandom_range(0, 99) < rprob),
                      16'($urandom));
            end
        end

        @(posedge clk);
        #1;
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
